// File: rtl/sat_add_arbiter.sv
// sat_add_arbiter: two-requester round-robin front end feeding a single
// saturating unsigned adder. A result is held in the output registers until
// the consumer takes it, and no new operands are accepted while it is held.
// Optional feature macro: SAT_CNT_EN adds an 8-bit saturating count of
// saturated results on port sat_count.
module sat_add_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req0_ready,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_sat,
    output logic             rsp_id
`ifdef SAT_CNT_EN
    ,
    output logic [7:0]       sat_count
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t             state_q;
    logic               rsp_valid_q;
    logic [WIDTH-1:0]   sum_q;
    logic               sat_q;
    logic               id_q;
    logic               last_q;     // requester granted by the most recent handshake

    logic               grant0;
    logic               grant1;
    logic               accept;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [WIDTH:0]     sum_full;
    logic [WIDTH-1:0]   sum_d;
    logic               sat_d;

    // Round-robin grant and saturating add of the granted operand pair.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && (state_q == IDLE)) begin
            if (req0_valid && req1_valid) begin
                // Contention: the requester that did not win last time wins now.
                grant0 = last_q;
                grant1 = ~last_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end else begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end

        accept = grant0 | grant1;

        if (grant1) begin
            sel_a = req1_a;
            sel_b = req1_b;
        end else begin
            sel_a = req0_a;
            sel_b = req0_b;
        end

        sum_full = {1'b0, sel_a} + {1'b0, sel_b};
        sat_d    = sum_full[WIDTH];
        if (sum_full[WIDTH]) begin
            sum_d = {WIDTH{1'b1}};
        end else begin
            sum_d = sum_full[WIDTH-1:0];
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Response FSM: capture a result on handshake, hold it until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            sum_q       <= {WIDTH{1'b0}};
            sat_q       <= 1'b0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        sum_q       <= sum_d;
                        sat_q       <= sat_d;
                        id_q        <= grant1;
                        last_q      <= grant1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_sat   = sat_q;
    assign rsp_id    = id_q;

`ifdef SAT_CNT_EN
    logic [7:0] sat_cnt_q;

    // Count saturating results at the accepting handshake, sticking at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt_q <= 8'd0;
        end else if (accept && sat_d && (sat_cnt_q != 8'hFF)) begin
            sat_cnt_q <= sat_cnt_q + 8'd1;
        end
    end

    assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Self-checking bench for sat_add_arbiter (WIDTH=4) with a behavioural model.
module tb_sat_add_arbiter;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_sat, rsp_id;
`ifdef SAT_CNT_EN
    logic [7:0]   sat_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit           m_busy;
    int           m_last;
    logic [W-1:0] m_sum;
    bit           m_sat;
    int           m_id;
    int           m_cnt;

    logic obs_r0, obs_r1, exp_r0, exp_r1;

    always #5 clk = ~clk;

    sat_add_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_sat    (rsp_sat),
        .rsp_id     (rsp_id)
`ifdef SAT_CNT_EN
        ,
        .sat_count  (sat_count)
`endif
    );

    // Drive one cycle of inputs, record readies, advance the clock and model.
    task automatic do_cycle(input logic r, input logic v0, input logic [W-1:0] a0,
                            input logic [W-1:0] b0, input logic v1,
                            input logic [W-1:0] a1, input logic [W-1:0] b1,
                            input logic rr);
        int g;
        int s;
        rst = r; req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1; rsp_ready = rr;
        #1;
        obs_r0 = req0_ready;
        obs_r1 = req1_ready;
        g = -1;
        if (!r && !m_busy) begin
            if (v0 && v1)  g = 1 - m_last;
            else if (v0)   g = 0;
            else if (v1)   g = 1;
        end
        exp_r0 = (g == 0);
        exp_r1 = (g == 1);
        @(posedge clk);
        #1;
        if (r) begin
            m_busy = 0; m_last = 1; m_sum = '0; m_sat = 0; m_id = 0; m_cnt = 0;
        end else if (g >= 0) begin
            s = (g == 0) ? (int'(a0) + int'(b0)) : (int'(a1) + int'(b1));
            m_busy = 1; m_last = g; m_id = g;
            if (s > MAXV) begin
                m_sum = {W{1'b1}};
                m_sat = 1;
                if (m_cnt < 255) m_cnt++;
            end else begin
                m_sum = s[W-1:0];
                m_sat = 0;
            end
        end else if (m_busy && rr) begin
            m_busy = 0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b1, 1'b1, 4'd3, 4'd3, 1'b1, 4'd4, 4'd4, 1'b1);
            n_checks++;
            if ({obs_r0, obs_r1} !== 2'b00) begin
                n_fail++; $display("FAIL reset_ready got %b%b exp 00", obs_r0, obs_r1);
            end
            n_checks++;
            if ({rsp_valid, rsp_sum, rsp_sat, rsp_id} !== {1'b0, 4'd0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_outputs got v=%b sum=%0d sat=%b id=%b exp all 0",
                         rsp_valid, rsp_sum, rsp_sat, rsp_id);
            end
        end
`ifdef SAT_CNT_EN
        n_checks++;
        if (sat_count !== 8'd0) begin
            n_fail++; $display("FAIL reset_satcnt got %0d exp 0", sat_count);
        end
`endif
    endtask

    task automatic test_basic();
        do_cycle(1'b0, 1'b1, 4'd5, 4'd6, 1'b0, 4'd0, 4'd0, 1'b1);
        n_checks++;
        if ({obs_r0, obs_r1} !== 2'b10) begin
            n_fail++; $display("FAIL basic_ready0 got %b%b exp 10", obs_r0, obs_r1);
        end
        n_checks++;
        if ({rsp_valid, rsp_sum, rsp_sat, rsp_id} !== {1'b1, 4'd11, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_sum got v=%b sum=%0d sat=%b id=%b exp v=1 sum=11 sat=0 id=0",
                     rsp_valid, rsp_sum, rsp_sat, rsp_id);
        end
        do_cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1);
        n_checks++;
        if ({obs_r0, obs_r1, rsp_valid} !== 3'b000) begin
            n_fail++; $display("FAIL basic_drain got r=%b%b v=%b exp 000", obs_r0, obs_r1, rsp_valid);
        end
        do_cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd15, 4'd1, 1'b1);
        n_checks++;
        if ({obs_r0, obs_r1} !== 2'b01) begin
            n_fail++; $display("FAIL basic_ready1 got %b%b exp 01", obs_r0, obs_r1);
        end
        n_checks++;
        if ({rsp_valid, rsp_sum, rsp_sat, rsp_id} !== {1'b1, 4'd15, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_sat got v=%b sum=%0d sat=%b id=%b exp v=1 sum=15 sat=1 id=1",
                     rsp_valid, rsp_sum, rsp_sat, rsp_id);
        end
`ifdef SAT_CNT_EN
        n_checks++;
        if (sat_count !== 8'd1) begin
            n_fail++; $display("FAIL basic_satcnt got %0d exp 1", sat_count);
        end
`endif
        do_cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1);
    endtask

    task automatic test_round_robin();
        logic [W-1:0] a0, b0, a1, b1;
        logic [31:0]  rnd;
        do_cycle(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            rnd = $urandom;
            a0 = rnd[3:0]; b0 = rnd[7:4]; a1 = rnd[11:8]; b1 = rnd[15:12];
            do_cycle(1'b0, 1'b1, a0, b0, 1'b1, a1, b1, 1'b1);
            n_checks++;
            if (rsp_valid !== ((k % 2) == 0)) begin
                n_fail++; $display("FAIL rr_valid cycle %0d got %b exp %b", k, rsp_valid, (k % 2) == 0);
            end
            if ((k % 2) == 0) begin
                n_checks++;
                if ((rsp_id !== 1'((k / 2) % 2)) || (rsp_sum !== m_sum) || (rsp_sat !== m_sat)) begin
                    n_fail++;
                    $display("FAIL rr_result cycle %0d got id=%b sum=%0d sat=%b exp id=%0d sum=%0d sat=%b",
                             k, rsp_id, rsp_sum, rsp_sat, (k / 2) % 2, m_sum, m_sat);
                end
            end
        end
        do_cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1);
    endtask

    task automatic test_backpressure();
        do_cycle(1'b0, 1'b1, 4'd7, 4'd8, 1'b0, 4'd0, 4'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b0, 1'b1, 4'(i), 4'd9, 1'b1, 4'd2, 4'(i), 1'b0);
            n_checks++;
            if ({obs_r0, obs_r1} !== 2'b00) begin
                n_fail++; $display("FAIL bp_ready cycle %0d got %b%b exp 00", i, obs_r0, obs_r1);
            end
            n_checks++;
            if ({rsp_valid, rsp_sum, rsp_sat, rsp_id} !== {1'b1, 4'd15, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d got v=%b sum=%0d sat=%b id=%b exp v=1 sum=15 sat=0 id=0",
                         i, rsp_valid, rsp_sum, rsp_sat, rsp_id);
            end
        end
        do_cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1);
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_release got v=%b exp 0", rsp_valid);
        end
    endtask

    task automatic test_reset_in_resp();
        do_cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd2, 4'd3, 1'b0);
        n_checks++;
        if ({rsp_valid, rsp_sum, rsp_id} !== {1'b1, 4'd5, 1'b1}) begin
            n_fail++; $display("FAIL rir_setup got v=%b sum=%0d id=%b exp v=1 sum=5 id=1",
                               rsp_valid, rsp_sum, rsp_id);
        end
        do_cycle(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rir_discard got v=%b exp 0", rsp_valid);
        end
        do_cycle(1'b0, 1'b1, 4'd1, 4'd1, 1'b1, 4'd3, 4'd3, 1'b1);
        n_checks++;
        if ({obs_r0, obs_r1, rsp_valid, rsp_id, rsp_sum} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'd2}) begin
            n_fail++; $display("FAIL rir_first_grant got r=%b%b v=%b id=%b sum=%0d exp r=10 v=1 id=0 sum=2",
                               obs_r0, obs_r1, rsp_valid, rsp_id, rsp_sum);
        end
        do_cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] rnd;
        for (int i = 0; i < 400; i++) begin
            rnd = $urandom;
            do_cycle(rnd[4:0] == 5'd0, rnd[5], rnd[9:6], rnd[13:10], rnd[14],
                     rnd[18:15], rnd[22:19], rnd[24:23] != 2'b00);
            n_checks++;
            if ({obs_r0, obs_r1} !== {exp_r0, exp_r1}) begin
                n_fail++; $display("FAIL rand_ready cycle %0d got %b%b exp %b%b", i, obs_r0, obs_r1, exp_r0, exp_r1);
            end
            n_checks++;
            if (rsp_valid !== m_busy) begin
                n_fail++; $display("FAIL rand_valid cycle %0d got %b exp %b", i, rsp_valid, m_busy);
            end
            if (m_busy) begin
                n_checks++;
                if ({rsp_sum, rsp_sat, rsp_id} !== {m_sum, m_sat, m_id[0]}) begin
                    n_fail++;
                    $display("FAIL rand_result cycle %0d got sum=%0d sat=%b id=%b exp sum=%0d sat=%b id=%0d",
                             i, rsp_sum, rsp_sat, rsp_id, m_sum, m_sat, m_id);
                end
            end
`ifdef SAT_CNT_EN
            n_checks++;
            if (sat_count !== m_cnt[7:0]) begin
                n_fail++; $display("FAIL rand_satcnt cycle %0d got %0d exp %0d", i, sat_count, m_cnt);
            end
`endif
        end
    endtask

`ifdef SAT_CNT_EN
    task automatic test_sat_count();
        int bad;
        bad = 0;
        do_cycle(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            do_cycle(1'b0, 1'b1, 4'd15, 4'd15, 1'b0, 4'd0, 4'd0, 1'b1);
            n_checks++;
            if ({rsp_valid, rsp_sum, rsp_sat} !== {1'b1, 4'd15, 1'b1}) begin
                n_fail++;
                if (bad < 5) $display("FAIL satcnt_sum op %0d got v=%b sum=%0d sat=%b exp v=1 sum=15 sat=1",
                                      i, rsp_valid, rsp_sum, rsp_sat);
                bad++;
            end
            do_cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1);
        end
        n_checks++;
        if (sat_count !== 8'd255) begin
            n_fail++; $display("FAIL satcnt_final got %0d exp 255", sat_count);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; rsp_ready = 1'b0;
        m_busy = 0; m_last = 1; m_sum = '0; m_sat = 0; m_id = 0; m_cnt = 0;
        #2;
        test_reset();
        test_basic();
        test_round_robin();
        test_backpressure();
        test_reset_in_resp();
        test_random();
`ifdef SAT_CNT_EN
        test_sat_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
